// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int ARB_NUM_M = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1,
    ARB_ERRW
  } arb_state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
  } wb_m2s_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall counter: fires on the TIMEOUT-th consecutive enabled cycle.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of stalled cycles before this one
  assign expired = en && !clr && (count == LIMIT);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone B4 classic arbiter with a stall watchdog.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [31:0]          m0_adr_i,
  input  logic [31:0]          m1_adr_i,
  input  logic [31:0]          m0_dat_i,
  input  logic [31:0]          m1_dat_i,
  input  logic [3:0]           m0_sel_i,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m1_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m1_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m1_stb_i,
  output logic [31:0]          m0_dat_o,
  output logic [31:0]          m1_dat_o,
  output logic                 m0_ack_o,
  output logic                 m1_ack_o,
  output logic                 m0_err_o,
  output logic                 m1_err_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  output logic [ARB_NUM_M-1:0] gnt_o,
  output logic                 timeout_o
);

  arb_state_t state;
  logic       last_served;
  wb_m2s_t    m0_req, m1_req, bus_req;
  logic       own0, own1;
  logic       wd_en, expired;

  assign m0_req = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i};
  assign m1_req = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i};

  always_comb begin
    bus_req = '0;
    case (state)
      ARB_OWN0: bus_req = m0_req;
      ARB_OWN1: bus_req = m1_req;
      default:  bus_req = '0;
    endcase
  end

  assign s_adr_o = bus_req.adr;
  assign s_dat_o = bus_req.dat;
  assign s_sel_o = bus_req.sel;
  assign s_we_o  = bus_req.we;
  assign s_cyc_o = bus_req.cyc;
  assign s_stb_o = bus_req.cyc & bus_req.stb;

  assign own0 = (state == ARB_OWN0);
  assign own1 = (state == ARB_OWN1);

  // A response in the same cycle as expiry suppresses it, since wd_en drops
  assign wd_en = s_stb_o & ~s_ack_i & ~s_err_i;

  generate
    if (TIMEOUT > 0) begin : g_wd
      wb_arb_watchdog #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
      ) u_watchdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .en     (wd_en),
        .clr    (~wd_en),
        .expired(expired)
      );
    end else begin : g_no_wd
      assign expired = 1'b0;
    end
  endgenerate

  assign timeout_o = expired;
  assign m0_ack_o  = own0 & s_ack_i;
  assign m1_ack_o  = own1 & s_ack_i;
  assign m0_err_o  = own0 & (s_err_i | expired);
  assign m1_err_o  = own1 & (s_err_i | expired);
  assign m0_dat_o  = own0 ? s_dat_i : 32'h0;
  assign m1_dat_o  = own1 ? s_dat_i : 32'h0;

  // Grant and ownership change only through IDLE, so every handover costs one cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ARB_IDLE;
      gnt_o       <= '0;
      last_served <= 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_served)) begin
            state <= ARB_OWN0;
            gnt_o <= 2'b01;
          end else if (m1_cyc_i) begin
            state <= ARB_OWN1;
            gnt_o <= 2'b10;
          end
        end
        ARB_OWN0: begin
          if (expired) begin
            state <= ARB_ERRW;
          end else if (!m0_cyc_i) begin
            state       <= ARB_IDLE;
            gnt_o       <= '0;
            last_served <= 1'b0;
          end
        end
        ARB_OWN1: begin
          if (expired) begin
            state <= ARB_ERRW;
          end else if (!m1_cyc_i) begin
            state       <= ARB_IDLE;
            gnt_o       <= '0;
            last_served <= 1'b1;
          end
        end
        ARB_ERRW: begin
          if ((gnt_o[0] && !m0_cyc_i) || (gnt_o[1] && !m1_cyc_i)) begin
            state       <= ARB_IDLE;
            gnt_o       <= '0;
            last_served <= gnt_o[1];
          end
        end
        default: begin
          state <= ARB_IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

endmodule
